// File: rtl/uart_pkg.sv
// Shared UART definitions used by the frame transmitter and the matching
// receiver.
// Contents: frame header byte, CRC-8 polynomial, frame FSM state encoding,
// and a one-byte CRC-8 update function (MSB first, no reflection).
package uart_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4,
        ST_DONE    = 3'd5
    } frame_state_t;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   load       : start sending data; honoured only while idle is high
//   data       : byte to send, sampled on an honoured load
//   tx         : serial line, idle high
//   idle       : engine can take a load this cycle
// idle is also high during the final cycle of a stop bit, so a load issued
// then starts the next start bit with no gap between bytes.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_BIT    = 4'd9;

    logic        active;
    logic [8:0]  shift;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic        bit_end;
    logic        stop_end;

    assign bit_end  = (baud_cnt == 16'd0);
    assign stop_end = active && bit_end && (bit_cnt == STOP_BIT);
    assign idle     = !active || stop_end;

    // bit_cnt is the index of the bit currently on the line:
    // 0 = start, 1..8 = data LSB first, 9 = stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load && idle) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            shift    <= {1'b1, data};
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= '0;
        end else if (active) begin
            if (bit_end) begin
                if (bit_cnt == STOP_BIT) begin
                    active  <= 1'b0;
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    tx       <= shift[0];
                    shift    <= {1'b0, shift[8:1]};
                    bit_cnt  <= bit_cnt + 4'd1;
                    baud_cnt <= BAUD_RELOAD;
                end
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: sends A5, LEN, LEN payload bytes, CRC-8.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   start       : one-cycle frame request, honoured only in IDLE
//   len         : payload length, clamped to MAX_LEN when captured
//   data_in     : payload byte, with data_valid / data_ready handshake
//   tx          : serial line, idle high
//   busy        : frame in progress (HDR through DONE)
//   done        : one-cycle pulse after the CRC stop bit
//
// state   | meaning
// IDLE    | waiting for start
// HDR     | header byte on the line
// LEN     | length byte on the line
// PAYLOAD | accepting and sending payload bytes
// CRC     | CRC byte on the line
// DONE    | one-cycle completion pulse
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int MAX_LEN      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] len,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);

    frame_state_t state, state_next;

    logic [4:0] len_q;
    logic [4:0] byte_cnt;
    logic [7:0] crc;
    logic [4:0] len_clamped;
    logic       eng_load;
    logic       eng_idle;
    logic [7:0] eng_data;
    logic       payload_left;
    logic       take_byte;

    assign len_clamped  = (len > MAX_LEN_C) ? MAX_LEN_C : len;
    assign payload_left = (byte_cnt != len_q);
    assign take_byte    = data_ready && data_valid;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .reset(reset),
        .load (eng_load),
        .data (eng_data),
        .tx   (tx),
        .idle (eng_idle)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // eng_idle inside a send state marks the last cycle of that byte's stop bit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_HDR;
            ST_HDR:     if (eng_idle) state_next = ST_LEN;
            ST_LEN:     if (eng_idle) state_next = (len_q == 5'd0) ? ST_CRC : ST_PAYLOAD;
            ST_PAYLOAD: if (eng_idle && !payload_left) state_next = ST_CRC;
            ST_CRC:     if (eng_idle) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The next byte is loaded on the same cycle the FSM leaves the current
    // send state, so bytes go out back to back.
    always_comb begin
        eng_load   = 1'b0;
        eng_data   = HDR_BYTE;
        data_ready = 1'b0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                eng_load = start;
                eng_data = HDR_BYTE;
            end
            ST_HDR: begin
                eng_load = eng_idle;
                eng_data = {3'b000, len_q};
            end
            ST_LEN: begin
                eng_load = eng_idle && (len_q == 5'd0);
                eng_data = crc;
            end
            ST_PAYLOAD: begin
                data_ready = eng_idle && payload_left;
                if (data_ready && data_valid) begin
                    eng_load = 1'b1;
                    eng_data = data_in;
                end else if (eng_idle && !payload_left) begin
                    eng_load = 1'b1;
                    eng_data = crc;
                end
            end
            default: begin
                eng_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            byte_cnt <= '0;
            crc      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len_clamped;
                        byte_cnt <= '0;
                        crc      <= '0;
                    end
                end
                ST_HDR: begin
                    // CRC covers the length byte, folded in as it is loaded.
                    if (eng_idle) crc <= crc8_update(8'h00, {3'b000, len_q});
                end
                ST_PAYLOAD: begin
                    if (take_byte) begin
                        crc      <= crc8_update(crc, data_in);
                        byte_cnt <= byte_cnt + 5'd1;
                    end else if (eng_idle && !payload_left) begin
                        byte_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
